alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter.sv | 163 ++++++++++++++++
 tb/tb_alu_iter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - iterative 32-bit ALU: single-cycle logic/arith, 32-step multiply and divide
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   IA           operation: ADD SUB MULT DIV OR AND SLT SLL(NOP when Sh=0)
//   A, B, Sh     operands and shift amount, captured on an accepted Start
//   Start        request, honoured only while idle
//   Res, ResHi   result low/high word (MULT product, DIV quotient/remainder)
//   Zero         Res == 0
//   Busy         multiply/divide iteration in progress
//   Done         one-cycle pulse when the result registers update
//   DivZ         last completed operation was a divide by zero
module alu_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  IA,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Sh,
  input  logic        Start,
  output logic [31:0] Res,
  output logic [31:0] ResHi,
  output logic        Zero,
  output logic        Busy,
  output logic        Done,
  output logic        DivZ
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t      r_state;
  logic [31:0] r_res;
  logic [31:0] r_reshi;
  logic        r_zero;
  logic        r_busy;
  logic        r_done;
  logic        r_divz;
  // Shared iteration datapath: r_hi is the product high half / partial
  // remainder, r_lo the multiplier / dividend being shifted out.
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_b;
  logic [4:0]  r_cnt;

  logic [31:0] w_single;
  logic [32:0] w_mul_sum;
  logic [31:0] w_div_low;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [31:0] w_next_hi;
  logic [31:0] w_next_lo;

  always_comb begin
    w_single = '0;
    case (IA)
      OP_ADD:  w_single = A + B;
      OP_SUB:  w_single = A - B;
      OP_OR:   w_single = A | B;
      OP_AND:  w_single = A & B;
      OP_SLT:  w_single = {31'd0, ($signed(A) < $signed(B))};
      OP_SLL:  w_single = B << Sh;
      default: w_single = '0;
    endcase
  end

  // Multiply step: add multiplicand when the multiplier LSB is set, then
  // shift the 65-bit {carry, hi, lo} right by one.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);

  // Divide step: shifted remainder is {r_hi, r_lo[31]} (33 bits). Its top bit
  // is r_hi[31]; if set the value already exceeds any 32-bit divisor, and the
  // 32-bit modulo difference is still exact because the true result < 2^32.
  assign w_div_low = {r_hi[30:0], r_lo[31]};
  assign w_div_ge  = r_hi[31] | (w_div_low >= r_b);
  assign w_div_sub = w_div_low - r_b;

  always_comb begin
    w_next_hi = w_mul_sum[32:1];
    w_next_lo = {w_mul_sum[0], r_lo[31:1]};
    if (r_state == S_DIV) begin
      w_next_hi = w_div_ge ? w_div_sub : w_div_low;
      w_next_lo = {r_lo[30:0], w_div_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_res   <= '0;
      r_reshi <= '0;
      r_zero  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_divz  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (IA == OP_MUL || (IA == OP_DIV && B != '0)) begin
              r_hi    <= '0;
              r_lo    <= A;
              r_b     <= B;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= (IA == OP_MUL) ? S_MUL : S_DIV;
            end else if (IA == OP_DIV) begin
              r_res   <= '1;
              r_reshi <= A;
              r_zero  <= 1'b0;
              r_divz  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_res   <= w_single;
              r_reshi <= '0;
              r_zero  <= (w_single == '0);
              r_divz  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_hi  <= w_next_hi;
          r_lo  <= w_next_lo;
          r_cnt <= r_cnt + 5'd1;
          // The 32nd step writes straight into the result registers so the
          // FIN cycle carries Done.
          if (r_cnt == 5'd31) begin
            r_res   <= w_next_lo;
            r_reshi <= w_next_hi;
            r_zero  <= (w_next_lo == '0);
            r_divz  <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FIN;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Res   = r_res;
  assign ResHi = r_reshi;
  assign Zero  = r_zero;
  assign Busy  = r_busy;
  assign Done  = r_done;
  assign DivZ  = r_divz;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - self-checking bench for alu_iter with a behavioural reference model
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  IA = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  Sh = '0;
  logic        Start = 1'b0;
  logic [31:0] Res;
  logic [31:0] ResHi;
  logic        Zero;
  logic        Busy;
  logic        Done;
  logic        DivZ;

  always #5 clk = ~clk;

  alu_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .IA    (IA),
    .A     (A),
    .B     (B),
    .Sh    (Sh),
    .Start (Start),
    .Res   (Res),
    .ResHi (ResHi),
    .Zero  (Zero),
    .Busy  (Busy),
    .Done  (Done),
    .DivZ  (DivZ)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results from plain arithmetic, timing as a countdown of
  // cycles until the result appears, plus a one-cycle "finishing" window in
  // which a new request is dropped.
  logic [31:0] m_res = '0;
  logic [31:0] m_hi = '0;
  logic        m_zero = 1'b1;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_divz = 1'b0;
  logic        m_fin = 1'b0;
  int          m_cnt = 0;
  logic [31:0] p_res = '0;
  logic [31:0] p_hi = '0;
  logic [63:0] prod = '0;

  task automatic m_post(input logic [31:0] r, input logic [31:0] h, input logic dz);
    m_res  = r;
    m_hi   = h;
    m_zero = (r == 32'd0);
    m_divz = dz;
    m_done = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res = '0; m_hi = '0; m_zero = 1'b1; m_busy = 1'b0;
      m_done = 1'b0; m_divz = 1'b0; m_fin = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_fin) begin
        m_fin = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_post(p_res, p_hi, 1'b0);
          m_busy = 1'b0;
          m_fin  = 1'b1;
        end
      end else if (Start) begin
        case (IA)
          3'd0: m_post(A + B, 32'd0, 1'b0);
          3'd1: m_post(A - B, 32'd0, 1'b0);
          3'd2: begin
            prod   = {32'd0, A} * {32'd0, B};
            p_res  = prod[31:0];
            p_hi   = prod[63:32];
            m_cnt  = 32;
            m_busy = 1'b1;
          end
          3'd3: begin
            if (B == 32'd0) m_post(32'hFFFFFFFF, A, 1'b1);
            else begin
              p_res  = A / B;
              p_hi   = A % B;
              m_cnt  = 32;
              m_busy = 1'b1;
            end
          end
          3'd4: m_post(A | B, 32'd0, 1'b0);
          3'd5: m_post(A & B, 32'd0, 1'b0);
          3'd6: m_post(($signed(A) < $signed(B)) ? 32'd1 : 32'd0, 32'd0, 1'b0);
          default: m_post(B << Sh, 32'd0, 1'b0);
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_res",   Res,   m_res);
    chk("cyc_reshi", ResHi, m_hi);
    chk("cyc_zero",  Zero,  m_zero);
    chk("cyc_busy",  Busy,  m_busy);
    chk("cyc_done",  Done,  m_done);
    chk("cyc_divz",  DivZ,  m_divz);
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    IA = op; A = a; B = b; Sh = sh; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    IA = 3'($urandom); A = $urandom; B = $urandom; Sh = 5'($urandom);
  endtask

  task automatic wait_done(input int exp_lat, input string name, input bit poke);
    int lat;
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      if (poke) begin
        Start = 1'($urandom); IA = 3'($urandom); A = $urandom; B = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    Start = 1'b0;
    chk(name, lat, exp_lat);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_res"},   Res,   64'h0);
    chk({tag, "_reshi"}, ResHi, 64'h0);
    chk({tag, "_zero"},  Zero,  64'h1);
    chk({tag, "_busy"},  Busy,  64'h0);
    chk({tag, "_done"},  Done,  64'h0);
    chk({tag, "_divz"},  DivZ,  64'h0);
  endtask

  initial begin
    int nd;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'h7FFFFFFF, 32'h1, 5'd0);
    wait_done(1, "lat_add", 1'b0);
    chk("add_res", Res, 64'h80000000);
    chk("add_zero", Zero, 64'h0);
    @(negedge clk);
    chk("add_done_pulse", Done, 64'h0);
    chk("add_hold", Res, 64'h80000000);

    issue(3'd1, 32'd5, 32'd5, 5'd0);
    wait_done(1, "lat_sub", 1'b0);
    chk("sub_res", Res, 64'h0);
    chk("sub_zero", Zero, 64'h1);
    issue(3'd0, 32'hFFFFFFFF, 32'h1, 5'd0);
    wait_done(1, "lat_wrap", 1'b0);
    chk("wrap_res", Res, 64'h0);
    issue(3'd6, 32'hFFFFFFFF, 32'h1, 5'd0);
    wait_done(1, "lat_slt1", 1'b0);
    chk("slt1_res", Res, 64'h1);
    issue(3'd6, 32'h1, 32'hFFFFFFFF, 5'd0);
    wait_done(1, "lat_slt2", 1'b0);
    chk("slt2_res", Res, 64'h0);
    issue(3'd7, 32'h0, 32'h3, 5'd4);
    wait_done(1, "lat_sll", 1'b0);
    chk("sll_res", Res, 64'h30);
    issue(3'd7, 32'h0, 32'hDEAD, 5'd0);
    wait_done(1, "lat_nop", 1'b0);
    chk("nop_res", Res, 64'hDEAD);

    issue(3'd2, 32'hFFFFFFFF, 32'h2, 5'd0);
    wait_done(33, "lat_mul", 1'b1);
    chk("mul_res", Res, 64'hFFFFFFFE);
    chk("mul_hi", ResHi, 64'h1);
    chk("mul_busy", Busy, 64'h0);
    IA = 3'd0; A = 32'd1; B = 32'd1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    chk("fin_ignore_done", Done, 64'h0);
    chk("fin_ignore_res", Res, 64'hFFFFFFFE);

    issue(3'd3, 32'd100, 32'd7, 5'd0);
    wait_done(33, "lat_div", 1'b1);
    chk("div_res", Res, 64'd14);
    chk("div_hi", ResHi, 64'd2);
    @(negedge clk);
    issue(3'd3, 32'd9, 32'd0, 5'd0);
    wait_done(1, "lat_divz", 1'b0);
    chk("divz_res", Res, 64'hFFFFFFFF);
    chk("divz_hi", ResHi, 64'd9);
    chk("divz_flag", DivZ, 64'h1);
    issue(3'd0, 32'd2, 32'd2, 5'd0);
    wait_done(1, "lat_b2b", 1'b0);
    chk("b2b_res", Res, 64'd4);
    chk("b2b_divz", DivZ, 64'h0);

    issue(3'd2, $urandom, $urandom, 5'd0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) nd++;
    end
    chk("abort_no_done", nd, 64'd0);
    issue(3'd0, 32'd2, 32'd3, 5'd0);
    wait_done(1, "lat_after_rst", 1'b0);
    chk("after_rst_res", Res, 64'd5);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          multi;
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 15));
        2: a = 32'hFFFFFFFF;
        default: ;
      endcase
      issue(op, a, b, 5'($urandom));
      multi = (op == 3'd2) || (op == 3'd3 && b != 32'd0);
      wait_done(multi ? 33 : 1, "lat_rand", 1'b1);
      if (multi) begin
        Start = 1'($urandom); IA = 3'($urandom);
        @(negedge clk);
        Start = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
